// File: rtl/read_ptr_empty_ctrl.sv
// Read-side pointer and empty-flag logic for the dual-clock FIFO.
// Consumes the synchronised Gray write pointer and drives the RAM read address and the read status.
module read_ptr_empty_ctrl #(
  parameter int ADDRESS_SIZE        = 4,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic                    rinc,
  input  logic                    rclr_err,
  input  logic [ADDRESS_SIZE:0]   rq2_write_ptr,
  output logic                    rempty,
  output logic [ADDRESS_SIZE-1:0] raddr,
  output logic [ADDRESS_SIZE:0]   read_ptr,
  output logic [ADDRESS_SIZE:0]   rcount,
  output logic                    ralmost_empty,
  output logic                    rvalid,
  output logic                    runderflow
);

  localparam int                  PW        = ADDRESS_SIZE + 1;
  localparam logic [ADDRESS_SIZE:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

  function automatic logic [ADDRESS_SIZE:0] bin2gray(input logic [ADDRESS_SIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDRESS_SIZE:0] gray2bin(input logic [ADDRESS_SIZE:0] g);
    logic [ADDRESS_SIZE:0] b;
    b[ADDRESS_SIZE] = g[ADDRESS_SIZE];
    for (int i = ADDRESS_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRESS_SIZE:0] rbin_r;
  logic [ADDRESS_SIZE:0] rbinnext_s;
  logic [ADDRESS_SIZE:0] rgraynext_s;
  logic [ADDRESS_SIZE:0] wbin_s;
  logic [ADDRESS_SIZE:0] occ_s;
  logic                  rd_ok_s;

  // Next-pointer and occupancy computation; the modulo wrap falls out of the full pointer width.
  always_comb begin
    rd_ok_s     = rinc & ~rempty;
    rbinnext_s  = rbin_r + {{ADDRESS_SIZE{1'b0}}, rd_ok_s};
    rgraynext_s = bin2gray(rbinnext_s);
    wbin_s      = gray2bin(rq2_write_ptr);
    occ_s       = wbin_s - rbinnext_s;
  end

  assign raddr = rbin_r[ADDRESS_SIZE-1:0];

  // Pointer, flag and status registers; empty compares the full Gray pointers, MSBs included.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_r        <= {PW{1'b0}};
      read_ptr      <= {PW{1'b0}};
      rempty        <= 1'b1;
      rcount        <= {PW{1'b0}};
      ralmost_empty <= 1'b1;
      rvalid        <= 1'b0;
      runderflow    <= 1'b0;
    end else begin
      rbin_r        <= rbinnext_s;
      read_ptr      <= rgraynext_s;
      rempty        <= (rgraynext_s == rq2_write_ptr);
      rcount        <= occ_s;
      ralmost_empty <= (occ_s <= AE_THRESH);
      rvalid        <= rd_ok_s;
      if (rinc & rempty) begin
        runderflow <= 1'b1;
      end else if (rclr_err) begin
        runderflow <= 1'b0;
      end else begin
        runderflow <= runderflow;
      end
    end
  end

endmodule

// File: tb/tb_read_ptr_empty_ctrl.sv
// Bench for read_ptr_empty_ctrl: directed vector table, hand-written wrap/reset sequences,
// and randomized traffic against an occupancy-based reference model.
module tb_read_ptr_empty_ctrl;

  localparam int AS   = 4;
  localparam int AE   = 2;
  localparam int PMOD = 32;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rinc;
  logic          rclr_err;
  logic [AS:0]   rq2_write_ptr;
  logic          rempty;
  logic [AS-1:0] raddr;
  logic [AS:0]   read_ptr;
  logic [AS:0]   rcount;
  logic          ralmost_empty;
  logic          rvalid;
  logic          runderflow;

  int n_pass = 0;
  int n_total = 0;

  // reference model state: reads and writes as plain counters modulo 2*depth
  int m_rptr, m_w, m_count;
  bit m_empty, m_ae, m_valid, m_uf;

  read_ptr_empty_ctrl #(.ADDRESS_SIZE(AS), .ALMOST_EMPTY_THRESH(AE)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rclr_err(rclr_err),
    .rq2_write_ptr(rq2_write_ptr), .rempty(rempty), .raddr(raddr),
    .read_ptr(read_ptr), .rcount(rcount), .ralmost_empty(ralmost_empty),
    .rvalid(rvalid), .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    bit rinc;
    bit clr;
    int w;
    int raddr;
    bit empty;
    int count;
    bit ae;
    bit valid;
    bit uf;
    int rp;
  } vec_t;

  vec_t vt[12];

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) % PMOD;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_rptr = 0; m_count = 0; m_empty = 1; m_ae = 1; m_valid = 0; m_uf = 0;
  endtask

  task automatic model_step(input bit ri, input bit clr, input int w);
    bit acc;
    acc  = ri && !m_empty;
    m_uf = (ri && m_empty) || (m_uf && !clr);
    if (acc) m_rptr = (m_rptr + 1) % PMOD;
    m_count = (w - m_rptr + PMOD) % PMOD;
    m_empty = (m_count == 0);
    m_ae    = (m_count <= AE);
    m_valid = acc;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".raddr"},      int'(raddr),         m_rptr % 16);
    chk({tag, ".read_ptr"},   int'(read_ptr),      gray(m_rptr));
    chk({tag, ".rempty"},     int'(rempty),        int'(m_empty));
    chk({tag, ".rcount"},     int'(rcount),        m_count);
    chk({tag, ".almost"},     int'(ralmost_empty), int'(m_ae));
    chk({tag, ".rvalid"},     int'(rvalid),        int'(m_valid));
    chk({tag, ".underflow"},  int'(runderflow),    int'(m_uf));
  endtask

  // drive one cycle of inputs, let the edge happen, then compare against the model
  task automatic cyc(input bit ri, input bit clr, input int w, input string tag);
    rinc = ri; rclr_err = clr; rq2_write_ptr = 5'(gray(w)); m_w = w;
    @(posedge rclk); #1;
    model_step(ri, clr, w);
    check_model(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".rempty"},   int'(rempty),        1);
    chk({tag, ".almost"},   int'(ralmost_empty), 1);
    chk({tag, ".read_ptr"}, int'(read_ptr),      0);
    chk({tag, ".raddr"},    int'(raddr),         0);
    chk({tag, ".rcount"},   int'(rcount),        0);
    chk({tag, ".rvalid"},   int'(rvalid),        0);
    chk({tag, ".underflow"},int'(runderflow),    0);
  endtask

  initial begin
    int w, occ, s;
    bit ri, clr;

    //            rinc clr  w  raddr empty cnt ae valid uf rp
    vt[0]  = '{1'b0, 1'b0, 3, 0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 0};
    vt[1]  = '{1'b1, 1'b0, 3, 1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1};
    vt[2]  = '{1'b1, 1'b0, 3, 2, 1'b0, 1, 1'b1, 1'b1, 1'b0, 3};
    vt[3]  = '{1'b1, 1'b0, 3, 3, 1'b1, 0, 1'b1, 1'b1, 1'b0, 2};
    vt[4]  = '{1'b1, 1'b0, 3, 3, 1'b1, 0, 1'b1, 1'b0, 1'b1, 2};
    vt[5]  = '{1'b1, 1'b0, 3, 3, 1'b1, 0, 1'b1, 1'b0, 1'b1, 2};
    vt[6]  = '{1'b0, 1'b1, 3, 3, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2};
    vt[7]  = '{1'b1, 1'b1, 3, 3, 1'b1, 0, 1'b1, 1'b0, 1'b1, 2};
    vt[8]  = '{1'b0, 1'b1, 3, 3, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2};
    vt[9]  = '{1'b0, 1'b0, 4, 3, 1'b0, 1, 1'b1, 1'b0, 1'b0, 2};
    vt[10] = '{1'b1, 1'b0, 5, 4, 1'b0, 1, 1'b1, 1'b1, 1'b0, 6};
    vt[11] = '{1'b1, 1'b0, 5, 5, 1'b1, 0, 1'b1, 1'b1, 1'b0, 7};

    rrst = 1'b1; rinc = 1'b0; rclr_err = 1'b0; rq2_write_ptr = 5'd0; m_w = 0;
    model_reset();
    #2;
    check_reset_vals("por");
    #10 rrst = 1'b0;

    // directed table: drain, underflow, clear priority, simultaneous read/write
    for (int i = 0; i < 12; i++) begin
      rinc = vt[i].rinc; rclr_err = vt[i].clr; rq2_write_ptr = 5'(gray(vt[i].w));
      @(posedge rclk); #1;
      model_step(vt[i].rinc, vt[i].clr, vt[i].w);
      m_w = vt[i].w;
      chk($sformatf("vec%0d.raddr", i),    int'(raddr),         vt[i].raddr);
      chk($sformatf("vec%0d.rempty", i),   int'(rempty),        int'(vt[i].empty));
      chk($sformatf("vec%0d.rcount", i),   int'(rcount),        vt[i].count);
      chk($sformatf("vec%0d.almost", i),   int'(ralmost_empty), int'(vt[i].ae));
      chk($sformatf("vec%0d.rvalid", i),   int'(rvalid),        int'(vt[i].valid));
      chk($sformatf("vec%0d.underflow", i),int'(runderflow),    int'(vt[i].uf));
      chk($sformatf("vec%0d.read_ptr", i), int'(read_ptr),      vt[i].rp);
    end

    // reset between edges mid-run
    rinc = 1'b0; rclr_err = 1'b0;
    #3 rrst = 1'b1; rq2_write_ptr = 5'd0; m_w = 0;
    #1 check_reset_vals("midrst");
    model_reset();
    #2 rrst = 1'b0;

    // full depth and wrap, first lap then second lap
    cyc(1'b0, 1'b0, 16, "full1");
    chk("full1.count16", int'(rcount), 16);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 16, "lap1");
    chk("lap1.read_ptr", int'(read_ptr), 5'b11000);
    chk("lap1.empty", int'(rempty), 1);
    cyc(1'b0, 1'b0, 0, "full2");
    chk("full2.count16", int'(rcount), 16);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 0, "lap2");
    chk("lap2.read_ptr", int'(read_ptr), 0);

    // reset with rvalid high and rbin=5
    cyc(1'b0, 1'b0, 8, "pre6");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8, "rd6");
    chk("rd6.raddr5", int'(raddr), 5);
    chk("rd6.rvalid", int'(rvalid), 1);
    rrst = 1'b1; rinc = 1'b0; rq2_write_ptr = 5'd0; m_w = 0;
    #1;
    chk("rst6.raddr", int'(raddr), 0);
    chk("rst6.rvalid", int'(rvalid), 0);
    chk("rst6.rempty", int'(rempty), 1);
    model_reset();
    #2 rrst = 1'b0;
    cyc(1'b0, 1'b0, 2, "post6");
    chk("post6.first_raddr", int'(raddr), 0);
    cyc(1'b1, 1'b0, 2, "post6rd");

    // randomized traffic with legal write-pointer steps
    w = m_w;
    for (int i = 0; i < 600; i++) begin
      occ = (w - m_rptr + PMOD) % PMOD;
      s = (i % 200 < 100) ? $urandom_range(0, 2) : (($urandom_range(0, 3) == 0) ? 1 : 0);
      if (occ + s > 16) s = 16 - occ;
      w = (w + s) % PMOD;
      ri = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 7) == 0);
      cyc(ri, clr, w, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/read_ptr_empty_ctrl.md
Name: read_ptr_empty_ctrl

Overview:
Read-side pointer and empty-flag generator for the dual-clock asynchronous FIFO. It is the read-domain counterpart that consumes the write pointer after the 2-flop synchroniser (rq2_write_ptr). It produces the FIFO RAM read address, the Gray read pointer sent back toward the write domain, and the registered empty flag. It also provides occupancy, almost-empty, read-valid and sticky underflow status for the read-side consumer.

Parameters:
ADDRESS_SIZE, 4, RAM address width; depth = 2^ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits.
ALMOST_EMPTY_THRESH, 2, ralmost_empty asserts when occupancy <= this value; legal range 0..2^ADDRESS_SIZE.

Ports:
rclk  input  1  read-domain clock; all state updates on its rising edge.
rrst  input  1  asynchronous, active-high reset; forces all state to reset values immediately.
rinc  input  1  read request; accepted only when rempty=0.
rclr_err  input  1  synchronous clear of runderflow.
rq2_write_ptr  input  ADDRESS_SIZE+1  Gray write pointer, already synchronised into rclk.
rempty  output  1  registered FIFO-empty flag.
raddr  output  ADDRESS_SIZE  binary RAM read address.
read_ptr  output  ADDRESS_SIZE+1  registered Gray read pointer, sent to the write-domain synchroniser.
rcount  output  ADDRESS_SIZE+1  registered occupancy as seen by the read domain, 0..2^ADDRESS_SIZE.
ralmost_empty  output  1  registered; high when occupancy <= ALMOST_EMPTY_THRESH.
rvalid  output  1  one-cycle pulse, one rclk after each accepted read.
runderflow  output  1  sticky error flag: set by a read attempt while empty.

Behaviour:
- Reset values (async on rrst=1): rbin=0, read_ptr=0, rempty=1, rcount=0, ralmost_empty=1, rvalid=0, runderflow=0. Reset asserted mid-operation discards all state; no pending pulse survives it.
- Accept: rd_ok = rinc & ~rempty.
- rbinnext = rbin + rd_ok, modulo 2^(ADDRESS_SIZE+1).
- rgraynext = (rbinnext >> 1) ^ rbinnext.
- On each edge: rbin <= rbinnext; read_ptr <= rgraynext.
- raddr = rbin[ADDRESS_SIZE-1:0], combinational from the register. The RAM presents data at raddr (first-word-fall-through). raddr wraps 2^ADDRESS_SIZE-1 -> 0; the MSB of rbin toggles on each wrap.
- rempty <= (rgraynext == rq2_write_ptr). Full Gray comparison including MSBs.
- Empty latency:
  - Deassertion lags the write by the synchroniser delay plus 1 rclk (pessimistic, safe).
  - Assertion takes effect on the same edge that consumes the last word.
- wbin_s = Gray-to-binary of rq2_write_ptr: bit i = XOR of bits [ADDRESS_SIZE:i]. Combinational.
- rcount <= (wbin_s - rbinnext) modulo 2^(ADDRESS_SIZE+1). Computed at full pointer width; the wrap is handled by the modulo.
- ralmost_empty <= ((wbin_s - rbinnext) <= ALMOST_EMPTY_THRESH).
- rvalid <= rd_ok.
- runderflow: set when rinc & rempty; cleared by rclr_err; set has priority over clear in the same cycle. While empty, rinc never moves any pointer.
- Simultaneous read and write-pointer advance in the same cycle: both are applied. rempty and rcount reflect the net result.
- rq2_write_ptr changes by at most one Gray step per write-clock cycle. Multi-step jumps seen in rclk are still handled correctly by the binary conversion.
- Write overflow is not detected here; it is the write side's responsibility.

Test Plan:
1. Reset: pulse rrst between edges -> outputs take reset values immediately, before any rclk edge: rempty=1, ralmost_empty=1, read_ptr=0, raddr=0, rcount=0, rvalid=0, runderflow=0.
2. Drain: rq2_write_ptr=5'b00010 (bin 3), rinc=0 -> next edge rempty=0, rcount=3, ralmost_empty=0. Then rinc=1 for 3 cycles -> raddr 0,1,2 then 3; rcount 2,1,0; ralmost_empty=1 from count 2; rempty=1 on the 3rd edge; read_ptr=5'b00010; rvalid high for 3 cycles.
3. Underflow: rempty=1, rinc=1 for 2 cycles -> raddr/read_ptr unchanged, rvalid=0, runderflow=1 and stays high. rclr_err=1 with rinc=0 -> runderflow=0. rclr_err=1 with rinc=1 while empty -> runderflow stays 1.
4. Wrap/full: rbin=0, rq2_write_ptr=5'b11000 (bin 16) -> rcount=16, rempty=0. 16 reads -> raddr 15->0, read_ptr=5'b11000, rempty=1. Repeat with write at bin 0 (second lap) -> rcount=16; pointer bin returns 31->0.
5. Simultaneous: rcount=1, rinc=1 on the same edge that rq2_write_ptr advances by one -> rempty stays 0, rcount=1, rvalid=1.
6. Reset mid-run: rbin=5 and rvalid=1, assert rrst -> raddr=0, rvalid=0, rempty=1 immediately. After release, the first read is at raddr 0.
